// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared constants and quadrature helpers for the paddle encoder
package breakout_pkg;

  localparam int CLK_DIV          = 1562;
  localparam int DEB_SAMPLES      = 4;
  localparam int STEPS_PER_DETENT = 4;
  localparam int POS_W            = 6;
  localparam int POS_MIN          = 0;
  localparam int POS_MAX          = 19;
  localparam int POS_RESET        = 10;

  // Encodings are the literal {a,b} channel levels.
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q10 = 2'b10,
    Q11 = 2'b11
  } quad_state_t;

  // Forward rotation walks 00->10->11->01->00; both-bits-changed yields no step.
  function automatic logic signed [1:0] quad_step(input quad_state_t prev, input quad_state_t cur);
    logic signed [1:0] step;
    step = 2'sd0;
    case ({prev, cur})
      {Q00, Q10}, {Q10, Q11}, {Q11, Q01}, {Q01, Q00}: step = 2'sd1;
      {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: step = -2'sd1;
      default: step = 2'sd0;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// rtl/quad_debounce.sv - two-flop synchroniser plus tick-sampled shift-register debounce for one channel
module quad_debounce
  import breakout_pkg::*;
#(
  parameter int DEB_SAMPLES_P = DEB_SAMPLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic level
);

  logic                     sync_0;
  logic                     sync_1;
  logic [DEB_SAMPLES_P-1:0] shift_q;
  logic [DEB_SAMPLES_P-1:0] shift_next;
  logic                     flip;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_0 <= 1'b0;
      sync_1 <= 1'b0;
    end else begin
      sync_0 <= raw;
      sync_1 <= sync_0;
    end
  end

  // Judge the level on the window that includes the sample being shifted in now.
  always_comb begin
    shift_next = DEB_SAMPLES_P'({shift_q, sync_1});
    flip       = level ? (shift_next == '0) : (shift_next == '1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      level   <= 1'b0;
    end else if (tick) begin
      shift_q <= shift_next;
      if (flip) begin
        level <= ~level;
      end
    end
  end

endmodule

// File: rtl/quad_paddle_encoder.sv
// rtl/quad_paddle_encoder.sv - quadrature rotary encoder to saturating paddle position
module quad_paddle_encoder
  import breakout_pkg::*;
#(
  parameter int CLK_DIV          = breakout_pkg::CLK_DIV,
  parameter int DEB_SAMPLES      = breakout_pkg::DEB_SAMPLES,
  parameter int STEPS_PER_DETENT = breakout_pkg::STEPS_PER_DETENT,
  parameter int POS_W            = breakout_pkg::POS_W,
  parameter int POS_MIN          = breakout_pkg::POS_MIN,
  parameter int POS_MAX          = breakout_pkg::POS_MAX,
  parameter int POS_RESET        = breakout_pkg::POS_RESET
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  output logic [POS_W-1:0] ctrl
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int ACC_W = $clog2(STEPS_PER_DETENT + 1) + 2;
  localparam logic signed [ACC_W-1:0] ACC_HI = ACC_W'(STEPS_PER_DETENT);
  localparam logic signed [ACC_W-1:0] ACC_LO = -ACC_HI;

  logic [CNT_W-1:0]        tick_cnt;
  logic                    tick;
  logic                    a_deb;
  logic                    b_deb;
  quad_state_t             cur_q;
  quad_state_t             prev_q;
  logic signed [1:0]       step;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_next;
  logic [POS_W-1:0]        ctrl_next;

  assign tick = (tick_cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  quad_debounce #(.DEB_SAMPLES_P(DEB_SAMPLES)) u_deb_a (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .raw     (a),
    .level   (a_deb)
  );

  quad_debounce #(.DEB_SAMPLES_P(DEB_SAMPLES)) u_deb_b (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .raw     (b),
    .level   (b_deb)
  );

  assign cur_q = quad_state_t'({a_deb, b_deb});
  assign step  = quad_step(prev_q, cur_q);

  // A full detent in either direction clears the sub-step count even when ctrl is pinned.
  always_comb begin
    acc_sum   = acc_q + {{(ACC_W-2){step[1]}}, step};
    acc_next  = acc_sum;
    ctrl_next = ctrl;
    if (acc_sum == ACC_HI) begin
      acc_next = '0;
      if (ctrl < POS_W'(POS_MAX)) begin
        ctrl_next = ctrl + 1'b1;
      end
    end else if (acc_sum == ACC_LO) begin
      acc_next = '0;
      if (ctrl > POS_W'(POS_MIN)) begin
        ctrl_next = ctrl - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= Q00;
      acc_q  <= '0;
      ctrl   <= POS_W'(POS_RESET);
    end else begin
      prev_q <= cur_q;
      acc_q  <= acc_next;
      ctrl   <= ctrl_next;
    end
  end

endmodule

// File: tb/tb_quad_paddle_encoder.sv
// tb/tb_quad_paddle_encoder.sv - self-checking bench for quad_paddle_encoder
module tb_quad_paddle_encoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic [5:0] ctrl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] ab;
    int         exp_ctrl;
  } vec_t;

  vec_t vecs[18];

  // Position of each {a,b} pair along the forward rotation ring.
  int ring_pos[4] = '{0, 3, 1, 2};

  int m_pos;
  int m_acc;
  int m_prev;

  quad_paddle_encoder #(
    .CLK_DIV          (4),
    .DEB_SAMPLES      (4),
    .STEPS_PER_DETENT (4),
    .POS_W            (6),
    .POS_MIN          (0),
    .POS_MAX          (19),
    .POS_RESET        (10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a),
    .b       (b),
    .ctrl    (ctrl)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: ctrl got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] ab, input int clocks);
    @(negedge clk);
    {a, b} = ab;
    repeat (clocks) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic detent(input logic fwd);
    logic [1:0] seq_f[4];
    logic [1:0] seq_r[4];
    seq_f = '{2'b10, 2'b11, 2'b01, 2'b00};
    seq_r = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      drive(fwd ? seq_f[i] : seq_r[i], 24);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    {a, b} = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_move(input logic [1:0] ab);
    int d;
    d = (ring_pos[ab] - ring_pos[m_prev] + 4) % 4;
    if (d == 1) m_acc++;
    else if (d == 3) m_acc--;
    m_prev = int'(ab);
    if (m_acc == 4) begin
      m_acc = 0;
      m_pos = (m_pos + 1 > 19) ? 19 : m_pos + 1;
    end else if (m_acc == -4) begin
      m_acc = 0;
      m_pos = (m_pos - 1 < 0) ? 0 : m_pos - 1;
    end
  endtask

  initial begin
    vecs = '{
      '{2'b10, 10}, '{2'b11, 10}, '{2'b01, 10}, '{2'b00, 11},
      '{2'b10, 11}, '{2'b11, 11}, '{2'b10, 11}, '{2'b00, 11},
      '{2'b11, 11}, '{2'b00, 11},
      '{2'b10, 11}, '{2'b11, 11}, '{2'b01, 11}, '{2'b00, 12},
      '{2'b01, 12}, '{2'b11, 12}, '{2'b10, 12}, '{2'b00, 11}
    };

    // Reset held while the channels toggle.
    for (int i = 0; i < 6; i++) begin
      {a, b} = 2'(i);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("reset_hold", int'(ctrl), 10);
    end
    {a, b} = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("reset_release", int'(ctrl), 10);

    // Detent, reversal and illegal-jump vectors.
    foreach (vecs[i]) begin
      drive(vecs[i].ab, 24);
      check($sformatf("vec%0d", i), int'(ctrl), vecs[i].exp_ctrl);
    end

    // Bounce rejection with three sub-steps pending, then an accepted pulse.
    drive(2'b10, 24);
    drive(2'b11, 24);
    drive(2'b01, 24);
    drive(2'b00, 8);
    drive(2'b01, 24);
    check("glitch_reject", int'(ctrl), 11);
    drive(2'b00, 24);
    check("pulse_accept", int'(ctrl), 12);
    drive(2'b01, 24);
    check("pulse_return", int'(ctrl), 12);

    // Saturation at the top, then one step back down.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      detent(1'b1);
      check($sformatf("sat_fwd%0d", i), int'(ctrl), (10 + i + 1 > 19) ? 19 : 10 + i + 1);
    end
    detent(1'b0);
    check("sat_rev", int'(ctrl), 18);

    // Asynchronous reset mid-detent discards the partial count.
    do_reset();
    detent(1'b1);
    drive(2'b10, 24);
    drive(2'b11, 24);
    #7;
    reset_n = 1'b0;
    #1;
    check("async_reset", int'(ctrl), 10);
    {a, b} = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    drive(2'b10, 24);
    drive(2'b11, 24);
    drive(2'b01, 24);
    check("post_reset_partial", int'(ctrl), 10);
    drive(2'b00, 24);
    check("post_reset_full", int'(ctrl), 11);

    // Randomised walk against the ring model, with short bounces sprinkled in.
    do_reset();
    m_pos  = 10;
    m_acc  = 0;
    m_prev = 0;
    for (int i = 0; i < 150; i++) begin
      logic [1:0] nxt;
      int         r;
      int         p;
      r = int'($urandom_range(0, 9));
      p = ring_pos[m_prev];
      if (r < 5) p = (p + 1) % 4;
      else if (r < 8) p = (p + 3) % 4;
      else p = (p + 2) % 4;
      nxt = 2'b00;
      for (int k = 0; k < 4; k++) begin
        if (ring_pos[k] == p) nxt = 2'(k);
      end
      drive(nxt, 24 + int'($urandom_range(0, 12)));
      model_move(nxt);
      if ($urandom_range(0, 2) == 0) begin
        logic [1:0] g;
        g = nxt ^ (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01);
        drive(g, int'($urandom_range(1, 8)));
        drive(nxt, 24);
      end
      check($sformatf("rand%0d", i), int'(ctrl), m_pos);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_paddle_encoder.md
Name: quad_paddle_encoder

Overview:
- Converts a mechanical quadrature rotary encoder (channels a/b) into a saturating 6-bit paddle position for the breakout video core.
- Runs in the 25 MHz pixel-clock domain.
- Contains input synchronisation, tick-based debounce, a Gray-code direction decoder and a detent accumulator.
- The display decoder consumes ctrl directly: paddle centre = (ctrl<<5)+8.

Parameters:
- CLK_DIV, 1562, pixel clocks per debounce sample tick (25 MHz/1562 ≈ 16 kHz).
- DEB_SAMPLES, 4, number of consecutive equal samples needed to accept a new level.
- STEPS_PER_DETENT, 4, valid quadrature transitions per position step.
- POS_W, 6, width of ctrl.
- POS_MIN, 0, lowest position.
- POS_MAX, 19, highest position.
- POS_RESET, 10, position after reset.

Ports:
- clk  in  1  25 MHz pixel clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a  in  1  raw encoder channel A, asynchronous to clk.
- b  in  1  raw encoder channel B, asynchronous to clk.
- ctrl  out  POS_W  current paddle position, registered.

Behaviour:
- Reset (async assert, sync release):
  - ctrl=POS_RESET; sub-step accumulator=0; tick counter=0.
  - Synchronisers, debounce shift registers and debounced levels all 0.
  - Previous-state register is loaded from debounced levels (00).
- Synchroniser: a and b each pass through two flops before any use.
- Tick generation:
  - Free-running counter 0..CLK_DIV-1.
  - tick=1 for exactly one cycle when the counter equals CLK_DIV-1, then the counter wraps to 0.
- Debounce (per channel, on tick only):
  - Shift the synchronised sample into a DEB_SAMPLES-bit register.
  - The debounced level changes only when all DEB_SAMPLES bits equal the opposite of the current level; otherwise it holds.
- Decoder: once per cycle, compare the debounced pair {a,b} with the previous pair, then store the current pair as previous.
  - Forward sequence 00→10→11→01→00: +1 substep.
  - Reverse sequence 00→01→11→10→00: −1 substep.
  - No change: 0.
  - Both bits changed (illegal): 0; previous pair is still updated, and there is no error output.
- Accumulator: signed, range −(STEPS_PER_DETENT−1)..+(STEPS_PER_DETENT−1).
  - Reaches +STEPS_PER_DETENT: accumulator←0 and ctrl←min(ctrl+1, POS_MAX).
  - Reaches −STEPS_PER_DETENT: accumulator←0 and ctrl←max(ctrl−1, POS_MIN).
  - At a limit, the accumulator still clears and ctrl holds (saturation, no wrap).
  - A direction reversal mid-detent unwinds the accumulator; no step is emitted.
- Latency: raw edge → debounced edge takes 2 sync cycles plus DEB_SAMPLES ticks (worst case DEB_SAMPLES+1 ticks). Debounced edge → ctrl update takes 1 cycle when it completes a detent.
- Bounce: a pulse shorter than DEB_SAMPLES consecutive ticks is rejected entirely.
- Reset mid-rotation: everything returns to reset values immediately; partial detents are lost.

Decomposition:
- Package breakout_pkg holds:
  - Default constants CLK_DIV, DEB_SAMPLES, STEPS_PER_DETENT, POS_MIN, POS_MAX, POS_RESET, POS_W.
  - Quadrature state encodings Q00, Q10, Q11, Q01.
- One natural sub-module, quad_debounce: sync pair plus tick-driven shift-register debounce for a single channel. It is instantiated twice.
- The tick counter lives in the top and is shared by both instances.

Test Plan (CLK_DIV=4, DEB_SAMPLES=4 for simulation):
- Reset: hold reset_n=0, toggle a/b → ctrl=10 throughout; after release with a=b=0, ctrl stays 10.
- One forward detent: drive 00→10→11→01→00, each level held 24 clocks → ctrl 10→11 exactly once, on the final transition.
- Saturation: 12 forward detents from reset → ctrl reaches 19 and stays 19. Then 1 reverse detent → ctrl=18.
- Glitch rejection: pulse a high for 8 clocks (2 ticks) → debounced a never changes, ctrl unchanged. A 24-clock pulse is accepted.
- Reversal mid-detent: 00→10→11 then 11→10→00 → ctrl unchanged, accumulator back to 0.
- Illegal jump: debounced 00→11 then 11→00 → no count; a subsequent valid forward detent still steps ctrl by exactly +1.
